// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode / operand-fetch stage in front of the 32-bit ALU. Accepts RV32I OP and
//   OP-IMM instructions, reads the integer register file it owns, and presents
//   registered operands to the ALU through a one-entry valid/ready output register.
//   It also owns the single register-file write port used by ALU writeback.
//
//   Build option: OPERAND_FETCH_BYPASS_EN
//     defined     - a writeback in the same cycle as an accept that reads the same
//                   nonzero register is forwarded, so the accepted operand is wb_data.
//     not defined - the accepted operand is the pre-write register value.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   instr_valid/ready upstream handshake; instr is the RV32I instruction word
//   wb_en/addr/data   register-file write port (writes to x0 are dropped)
//   out_valid/ready   downstream handshake
//   in1, in2_1, in2_2 rs1 value, rs2 value, sign-extended imm[31:20]
//   op                {instr[30], funct3, 1'b0, instr[5]}
//   alu_input_select  0: ALU uses in2_1 (OP), 1: ALU uses in2_2 (OP-IMM)
//   rd                destination index travelling with the operands
//   illegal           one-cycle pulse after an illegal instruction was accepted

module operand_fetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [31:0]               instr,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     in1,
    output logic [DATA_WIDTH-1:0]     in2_1,
    output logic [DATA_WIDTH-1:0]     in2_2,
    output logic [OP_WIDTH-1:0]       op,
    output logic                      alu_input_select,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      illegal
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]     regs_d [NUM_REGS];

    logic                      out_valid_q, out_valid_d;
    logic                      illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]     in1_q, in1_d;
    logic [DATA_WIDTH-1:0]     in2_1_q, in2_1_d;
    logic [DATA_WIDTH-1:0]     in2_2_q, in2_2_d;
    logic [OP_WIDTH-1:0]       op_q, op_d;
    logic                      sel_q, sel_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rs1_idx;
    logic [REG_ADDR_WIDTH-1:0] rs2_idx;
    logic [DATA_WIDTH-1:0]     rs1_val;
    logic [DATA_WIDTH-1:0]     rs2_val;
    logic                      legal;
    logic                      accept;

    assign instr_ready = !out_valid_q || out_ready;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        opcode  = instr[6:0];
        funct3  = instr[14:12];
        funct7  = instr[31:25];
        rs1_idx = instr[19:15];
        rs2_idx = instr[24:20];

        legal = 1'b0;
        if (opcode == OPC_OP) begin
            legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (opcode == OPC_OP_IMM) begin
            // Only the shift encodings constrain imm[11:5]; the rest take any immediate.
            case (funct3)
                3'b001:  legal = (funct7 == F7_ZERO);
                3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end

        rs1_val = regs_q[rs1_idx];
        rs2_val = regs_q[rs2_idx];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (wb_en && (wb_addr == rs1_idx)) rs1_val = wb_data;
        if (wb_en && (wb_addr == rs2_idx)) rs2_val = wb_data;
`endif
        // x0 is hard-wired; this also masks a forwarded write aimed at x0.
        if (rs1_idx == '0) rs1_val = '0;
        if (rs2_idx == '0) rs2_val = '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != '0)) regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = 1'b0;
        in1_d       = in1_q;
        in2_1_d     = in2_1_q;
        in2_2_d     = in2_2_q;
        op_d        = op_q;
        sel_d       = sel_q;
        rd_d        = rd_q;

        if (accept && legal) begin
            out_valid_d = 1'b1;
            in1_d       = rs1_val;
            in2_1_d     = rs2_val;
            in2_2_d     = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            op_d        = {instr[30], funct3, 1'b0, instr[5]};
            sel_d       = (opcode == OPC_OP_IMM);
            rd_d        = instr[11:7];
        end else if (accept) begin
            // Dropped instruction: any held entry is being consumed this cycle
            // (accept implies ready), so the output register simply empties.
            out_valid_d = 1'b0;
            illegal_d   = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            in1_q       <= '0;
            in2_1_q     <= '0;
            in2_2_q     <= '0;
            op_q        <= '0;
            sel_q       <= 1'b0;
            rd_q        <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            in1_q       <= in1_d;
            in2_1_q     <= in2_1_d;
            in2_2_q     <= in2_2_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign out_valid        = out_valid_q;
    assign illegal          = illegal_q;
    assign in1              = in1_q;
    assign in2_1            = in2_1_q;
    assign in2_2            = in2_2_q;
    assign op               = op_q;
    assign alu_input_select = sel_q;
    assign rd               = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in1;
    logic [31:0] in2_1;
    logic [31:0] in2_2;
    logic [5:0]  op;
    logic        alu_input_select;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2_1(in2_1), .in2_2(in2_2), .op(op),
        .alu_input_select(alu_input_select), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rdi);
        return {f7, rs2, rs1, f3, rdi, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rdi,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rdi, opc};
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        instr       = 32'h0;
        wb_en       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'h0;
        out_ready   = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        checks++; if ({in1, in2_1, in2_2} !== 96'h0) begin errors++; $display("FAIL reset_operands got %h %h %h exp 0", in1, in2_1, in2_2); end
        checks++; if ({op, alu_input_select, rd} !== 12'h0) begin errors++; $display("FAIL reset_op_sel_rd got %b %b %d exp 0", op, alu_input_select, rd); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %b exp 1", instr_ready); end
    endtask

    task automatic test_addi();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0010;
        step();
        wb_en = 1'b0;
        instr_valid = 1'b1;
        instr = i_type(12'hFFF, 5'd5, 3'b000, 5'd6, 7'b0010011);
        step();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_out_valid got %b exp 1", out_valid); end
        checks++; if (in1 !== 32'h10) begin errors++; $display("FAIL addi_in1 got %h exp 00000010", in1); end
        checks++; if (in2_2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_in2_2 got %h exp ffffffff", in2_2); end
        checks++; if (in2_1 !== 32'h0) begin errors++; $display("FAIL addi_in2_1 got %h exp 0 (x31)", in2_1); end
        checks++; if (op !== 6'b100000) begin errors++; $display("FAIL addi_op got %b exp 100000", op); end
        checks++; if (alu_input_select !== 1'b1) begin errors++; $display("FAIL addi_sel got %b exp 1", alu_input_select); end
        checks++; if (rd !== 5'd6) begin errors++; $display("FAIL addi_rd got %0d exp 6", rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_retire got %b exp 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        instr_valid = 1'b1;
        instr = r_type(7'b0100000, 5'd5, 5'd5, 3'b000, 5'd7);
        step();
        // A different instruction waits upstream while the held entry stalls.
        instr = i_type(12'd5, 5'd0, 3'b000, 5'd8, 7'b0010011);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL stall_hs_%0d got v=%b r=%b exp v=1 r=0", i, out_valid, instr_ready); end
            checks++; if (in1 !== 32'h10 || in2_1 !== 32'h10 || rd !== 5'd7) begin errors++; $display("FAIL stall_data_%0d got %h %h rd=%0d exp 10 10 rd=7", i, in1, in2_1, rd); end
            checks++; if (op !== 6'b100001 || alu_input_select !== 1'b0) begin errors++; $display("FAIL stall_op_%0d got %b sel=%b exp 100001 sel=0", i, op, alu_input_select); end
            step();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", instr_ready); end
        step();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd !== 5'd8 || in2_2 !== 32'd5 || in1 !== 32'd0) begin errors++; $display("FAIL stall_next got v=%b rd=%0d imm=%h in1=%h exp v=1 rd=8 imm=5 in1=0", out_valid, rd, in2_2, in1); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1;
        instr = i_type(12'h004, 5'd1, 3'b010, 5'd3, 7'b0000011);
        step();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_load got v=%b ill=%b exp v=0 ill=1", out_valid, illegal); end
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse_width got %b exp 0", illegal); end
        instr_valid = 1'b1;
        instr = i_type(12'h403, 5'd1, 3'b001, 5'd2, 7'b0010011);
        step();
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_slli got v=%b ill=%b exp v=0 ill=1", out_valid, illegal); end
        instr = i_type(12'h403, 5'd1, 3'b101, 5'd2, 7'b0010011);
        step();
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b0 || op !== 6'b110100 || rd !== 5'd2) begin errors++; $display("FAIL legal_srai got v=%b ill=%b op=%b rd=%0d exp v=1 ill=0 op=110100 rd=2", out_valid, illegal, op, rd); end
        instr = r_type(7'b0100000, 5'd1, 5'd1, 3'b001, 5'd4);
        step();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b1 || rd !== 5'd2) begin errors++; $display("FAIL illegal_sll_alt got v=%b ill=%b rd=%0d exp v=0 ill=1 rd=2", out_valid, illegal, rd); end
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_in1;
`ifdef OPERAND_FETCH_BYPASS_EN
        exp_in1 = 32'hDEAD_BEEF;
`else
        exp_in1 = 32'h0;
`endif
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
        instr_valid = 1'b1;
        instr = r_type(7'b0000000, 5'd0, 5'd9, 3'b000, 5'd1);
        step();
        wb_en = 1'b0;
        checks++; if (in1 !== exp_in1 || in2_1 !== 32'h0) begin errors++; $display("FAIL bypass_same_cycle got %h %h exp %h 0", in1, in2_1, exp_in1); end
        checks++; if (op !== 6'b000001 || alu_input_select !== 1'b0) begin errors++; $display("FAIL bypass_op got %b sel=%b exp 000001 sel=0", op, alu_input_select); end
        step();
        instr_valid = 1'b0;
        checks++; if (in1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_later got %h exp deadbeef", in1); end
        step();
    endtask

    task automatic test_x0();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        wb_en = 1'b0;
        instr_valid = 1'b1;
        instr = r_type(7'b0000000, 5'd0, 5'd0, 3'b110, 5'd2);
        step();
        instr_valid = 1'b0;
        checks++; if (in1 !== 32'h0 || in2_1 !== 32'h0) begin errors++; $display("FAIL x0_read got %h %h exp 0 0", in1, in2_1); end
        checks++; if (op !== 6'b011001 || rd !== 5'd2) begin errors++; $display("FAIL x0_or_op got %b rd=%0d exp 011001 rd=2", op, rd); end
        step();
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = i_type(12'(i + 1), 5'd0, 3'b000, 5'(10 + i), 7'b0010011);
            step();
            checks++; if (out_valid !== 1'b1 || rd !== 5'(10 + i) || in2_2 !== 32'(i + 1)) begin errors++; $display("FAIL b2b_%0d got v=%b rd=%0d imm=%h exp v=1 rd=%0d imm=%h", i, out_valid, rd, in2_2, 10 + i, i + 1); end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || rd !== 5'd0 || in2_2 !== 32'h0) begin errors++; $display("FAIL b2b_reset got v=%b rd=%0d imm=%h exp 0", out_valid, rd, in2_2); end
        instr = r_type(7'b0000000, 5'd9, 5'd5, 3'b000, 5'd1);
        step();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in1 !== 32'h0 || in2_1 !== 32'h0) begin errors++; $display("FAIL regs_cleared got v=%b %h %h exp v=1 0 0", out_valid, in1, in2_1); end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_stall();
        test_illegal();
        test_bypass();
        test_x0();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
